// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet-aware arbiter for a shared FIFO write port
// Optional afull throttle of new grants: FIFO_WR_ARB_AFULL_THROTTLE_EN
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    localparam int GID_W    = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_wr_en,
    output logic [DATA_W-1:0]         o_wr_data,
    input  logic                      i_full,
    input  logic                      i_afull,
    output logic [GID_W-1:0]          o_grant_id,
    output logic                      o_busy,
    output logic                      o_burst_trunc
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             r_state;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_burst_trunc;

    logic               w_throttle_ok;
    logic               w_grant_ok;
    logic               w_found;
    logic [GID_W-1:0]   w_winner;
    logic               w_beat;

    function automatic logic [GID_W-1:0] rr_idx(input logic [GID_W-1:0] p, input int k);
        return GID_W'((int'(p) + k) % NUM_REQ);
    endfunction

`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
    assign w_throttle_ok = !i_afull;
`else
    // afull only reaches this block for wiring; it never gates a grant
    assign w_throttle_ok = 1'b1 | i_afull;
`endif

    assign w_grant_ok = (|i_req_valid) && !i_full && w_throttle_ok;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req_valid[rr_idx(r_rr_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_beat = (r_state == S_BURST) && i_req_valid[r_grant_id] && !i_full;

    always_comb begin
        o_req_ready = '0;
        if (r_state == S_BURST && !i_full) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
    end

    assign o_wr_en       = w_beat;
    assign o_wr_data     = w_beat ? i_req_data[r_grant_id*DATA_W +: DATA_W] : '0;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = (r_state == S_BURST);
    assign o_burst_trunc = r_burst_trunc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= GID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_beat_cnt    <= '0;
            r_burst_trunc <= 1'b0;
        end else begin
            r_burst_trunc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ok && w_found) begin
                        r_grant_id <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (i_req_last[r_grant_id]) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= r_grant_id;
                        end else if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            r_state       <= S_IDLE;
                            r_rr_ptr      <= r_grant_id;
                            r_burst_trunc <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NR = 4, DW = 32, MB = 16, GW = 2, DEPTH = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [NR*DW-1:0]  req_data;
    logic              wr_en, full, afull, busy, burst_trunc;
    logic [DW-1:0]     wr_data;
    logic [GW-1:0]     grant_id;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_wr_en(wr_en), .o_wr_data(wr_data),
        .i_full(full), .i_afull(afull), .o_grant_id(grant_id), .o_busy(busy),
        .o_burst_trunc(burst_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [DW:0] pk [NR][DEPTH];
    int hd [NR];
    int tl [NR];
    int m_owner, m_ptr, m_gid, m_cnt;
    bit m_trunc;
    bit mdl_on = 1'b0;
    int obs_gid[$], obs_dat[$], obs_cyc[$];
    int ntrunc = 0, cyc = 0, c0 = 0;
    logic t_rst = 1'b1, t_full = 1'b0, t_afull = 1'b0;
    bit rnd_gate = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (hd[i] != tl[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int obs_g(int k);
        return (k < obs_gid.size()) ? obs_gid[k] : -1;
    endfunction

    function automatic int obs_d(int k);
        return (k < obs_dat.size()) ? obs_dat[k] : -1;
    endfunction

    function automatic int obs_c(int k);
        return (k < obs_cyc.size()) ? obs_cyc[k] : -1;
    endfunction

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        pk[i][tl[i]] = {l, d};
        tl[i]++;
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = NR - 1; m_gid = 0; m_cnt = 0; m_trunc = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (hd[i] != tl[i] && (!rnd_gate || $urandom_range(3) != 0)) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pk[i][hd[i]][DW-1:0];
                req_last[i]           = pk[i][hd[i]][DW];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = $urandom;
                req_last[i]           = 1'($urandom_range(1));
            end
        end
        rst = t_rst; full = t_full; afull = t_afull;
    endtask

    task automatic cycle();
        logic [NR-1:0] e_ready;
        logic          e_wr, sr, elig, found, lst;
        logic [DW-1:0] e_data;
        drive();
        #1;
        e_ready = '0; e_wr = 1'b0; e_data = '0;
        if (m_owner >= 0 && !full) begin
            e_ready[m_owner] = 1'b1;
            e_wr = req_valid[m_owner];
        end
        if (e_wr) e_data = req_data[m_owner*DW +: DW];
        if (mdl_on) begin
            chk("req_ready", req_ready, e_ready);
            chk("wr_en", wr_en, e_wr);
            chk("wr_data", wr_data, e_data);
            chk("busy", busy, m_owner >= 0);
            chk("grant_id", grant_id, m_gid);
            chk("burst_trunc", burst_trunc, m_trunc);
            chk("write_while_full", wr_en & full, 1'b0);
            if (burst_trunc) ntrunc++;
        end
        if (wr_en === 1'b1) begin
            obs_gid.push_back(int'(grant_id));
            obs_dat.push_back(int'(wr_data));
            obs_cyc.push_back(cyc);
        end
        sr = rst;
        @(posedge clk);
        #1;
        if (sr) begin
            model_reset();
            mdl_on = 1'b1;
        end else if (mdl_on) begin
            m_trunc = 1'b0;
            if (m_owner < 0) begin
                elig = (|req_valid) && !full;
`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
                elig = elig && !afull;
`endif
                found = 1'b0;
                if (elig) begin
                    for (int k = 1; k <= NR; k++) begin
                        if (!found && req_valid[(m_ptr + k) % NR]) begin
                            found = 1'b1;
                            m_owner = (m_ptr + k) % NR;
                            m_gid = m_owner;
                            m_cnt = 0;
                        end
                    end
                end
            end else if (e_wr) begin
                lst = pk[m_owner][hd[m_owner]][DW];
                hd[m_owner]++;
                m_cnt++;
                if (lst || m_cnt == MB) begin
                    m_trunc = !lst;
                    m_ptr = m_owner;
                    m_owner = -1;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_gid.delete(); obs_dat.delete(); obs_cyc.delete(); ntrunc = 0;
    endtask

    task automatic do_reset();
        t_rst = 1'b1;
        for (int i = 0; i < NR; i++) hd[i] = tl[i];
        cycle();
        cycle();
        t_rst = 1'b0;
        clear_obs();
        c0 = cyc;
    endtask

    task automatic run_drain(input int maxc, input string nm);
        int n = 0;
        while (!all_empty() && n < maxc) begin
            cycle();
            n++;
        end
        chk(nm, all_empty(), 1'b1);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
        model_reset();
        // reset with every requester valid, then round-robin over 1-beat packets
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < NR; i++) push(i, 32'h10 * i + p, 1'b1);
        @(negedge clk);
        cycle();
        cycle();
        t_rst = 1'b0;
        drive();
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_burst_trunc", burst_trunc, 1'b0);
        clear_obs();
        c0 = cyc;
        run_drain(40, "rr_timeout");
        chk("rr_first_cycle", obs_c(0), c0 + 1);
        for (int k = 0; k < 5; k++) chk("rr_order", obs_g(k), k % NR);
        for (int k = 0; k < 4; k++) chk("rr_spacing", obs_c(k + 1) - obs_c(k), 2);

        // single 3-beat packet from req1
        do_reset();
        for (int b = 0; b < 3; b++) push(1, 32'hA0 + b, b == 2);
        run_drain(20, "single_timeout");
        chk("single_count", obs_gid.size(), 3);
        chk("single_first_cycle", obs_c(0), c0 + 1);
        chk("single_consecutive", obs_c(2) - obs_c(0), 2);
        for (int k = 0; k < 3; k++) begin
            chk("single_data", obs_d(k), 32'hA0 + k);
            chk("single_gid", obs_g(k), 1);
        end
        chk("single_rr_ptr", m_ptr, 1);

        // full held for 5 cycles in the middle of a req2 packet
        do_reset();
        for (int b = 0; b < 6; b++) push(2, 32'hC0 + b, b == 5);
        cycle(); cycle(); cycle();
        t_full = 1'b1;
        for (int n = 0; n < 5; n++) cycle();
        t_full = 1'b0;
        run_drain(20, "bp_timeout");
        chk("bp_count", obs_gid.size(), 6);
        for (int k = 0; k < 6; k++) chk("bp_data", obs_d(k), 32'hC0 + k);
        chk("bp_gap", obs_c(2) - obs_c(1), 6);

        // 20 unterminated beats from req0 with req3 waiting
        do_reset();
        for (int b = 0; b < 20; b++) push(0, 32'h100 + b, 1'b0);
        push(3, 32'h300, 1'b1);
        run_drain(80, "trunc_timeout");
        chk("trunc_count", obs_gid.size(), 21);
        chk("trunc_pulses", ntrunc, 1);
        for (int k = 0; k < 21; k++) begin
            if (k < 16) begin
                chk("trunc_gid", obs_g(k), 0);
                chk("trunc_data", obs_d(k), 32'h100 + k);
            end else if (k == 16) begin
                chk("trunc_next_gid", obs_g(k), 3);
                chk("trunc_next_data", obs_d(k), 32'h300);
            end else begin
                chk("trunc_regrant_gid", obs_g(k), 0);
                chk("trunc_regrant_data", obs_d(k), 32'h100 + k - 1);
            end
        end

        // afull in IDLE; the reset also abandons req0's open grant
        do_reset();
        t_afull = 1'b1;
        push(0, 32'hD0, 1'b1);
        cycle(); cycle(); cycle();
`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
        chk("throttle_writes", obs_gid.size(), 0);
`else
        chk("throttle_writes", obs_gid.size(), 1);
        chk("throttle_cycle", obs_c(0), c0 + 1);
`endif
        t_afull = 1'b0;
        run_drain(20, "throttle_timeout");
        chk("throttle_final", obs_gid.size(), 1);
        chk("throttle_data", obs_d(0), 32'hD0);

        // randomized traffic, backpressure, afull and occasional resets
        do_reset();
        rnd_gate = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (hd[i] == tl[i] && $urandom_range(1) == 1) begin
                    int len;
                    len = $urandom_range(24, 1);
                    for (int b = 0; b < len; b++) push(i, $urandom, b == len - 1);
                end
            end
            t_full  = ($urandom_range(4) == 0);
            t_afull = ($urandom_range(2) == 0);
            t_rst   = ($urandom_range(299) == 0);
            cycle();
        end
        t_rst = 1'b0;
        t_full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
